// File: rtl/dpll_pkg.sv
// Shared widths, lock-state encoding and integrator saturation helper for the DPLL loop filter.
package dpll_pkg;

  localparam int unsigned DPLL_PW = 32;
  localparam int unsigned DPLL_MW = 16;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    LOSING   = 2'd3
  } lock_state_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  // Saturating add reduced to a clip decision: the caller forms the narrow sum itself,
  // which is exact whenever no clipping occurs.
  function automatic sat_e sat_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input logic signed [63:0] lim);
    logic signed [63:0] sum;
    sum = a + b;
    if (sum > lim)
      return SAT_HI;
    else if (sum < -lim)
      return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/dpll_lock_detect.sv
// Lock detector: hysteretic four-state FSM with a run-length counter, advanced once per sample.
module dpll_lock_detect
  import dpll_pkg::*;
#(
  parameter int unsigned     PW            = DPLL_PW,
  parameter logic [PW-1:0]   LOCK_THRESH   = 32'h0100_0000,
  parameter logic [PW-1:0]   UNLOCK_THRESH = 32'h0400_0000,
  parameter int unsigned     LOCK_COUNT    = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic          i_gate,
  input  logic [PW-1:0] i_ae,
  output logic          o_locked
);

  localparam int unsigned   CW   = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] ONE  = CW'(1);

  lock_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_lock, out_lock;

  assign in_lock  = i_gate && (i_ae < LOCK_THRESH);
  assign out_lock = !i_gate || (i_ae >= UNLOCK_THRESH);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= UNLOCKED;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (i_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (in_lock) begin
            state_d = ACQUIRE;
            count_d = ONE;
          end else begin
            count_d = '0;
          end
        end
        ACQUIRE: begin
          if (!in_lock) begin
            state_d = UNLOCKED;
            count_d = '0;
          end else if (count_q + ONE == LAST) begin
            state_d = LOCKED;
            count_d = '0;
          end else begin
            count_d = count_q + ONE;
          end
        end
        LOCKED: begin
          if (out_lock) begin
            state_d = LOSING;
            count_d = ONE;
          end else begin
            count_d = '0;
          end
        end
        LOSING: begin
          if (!out_lock) begin
            state_d = LOCKED;
            count_d = '0;
          end else if (count_q + ONE == LAST) begin
            state_d = UNLOCKED;
            count_d = '0;
          end else begin
            count_d = count_q + ONE;
          end
        end
        default: begin
          state_d = UNLOCKED;
          count_d = '0;
        end
      endcase
    end
  end

  assign o_locked = (state_q == LOCKED) || (state_q == LOSING);

endmodule

// File: rtl/dpll_loop_filter.sv
// DPLL PI loop filter: 3-stage pipeline from CORDIC phase error to NCO step, with lock detection.
module dpll_loop_filter
  import dpll_pkg::*;
#(
  parameter int unsigned   PW            = DPLL_PW,
  parameter int unsigned   MW            = DPLL_MW,
  parameter logic [MW-1:0] MAG_MIN       = 16'd256,
  parameter logic [PW-1:0] INT_LIM       = 32'h1000_0000,
  parameter logic [PW-1:0] LOCK_THRESH   = 32'h0100_0000,
  parameter logic [PW-1:0] UNLOCK_THRESH = 32'h0400_0000,
  parameter int unsigned   LOCK_COUNT    = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  input  logic [MW-1:0] i_mag,
  input  logic [PW-1:0] i_phase,
  input  logic [PW-1:0] i_base_step,
  input  logic [4:0]    i_kp_shift,
  input  logic [4:0]    i_ki_shift,
  input  logic          i_int_clr,
  output logic          o_valid,
  output logic [PW-1:0] o_step,
  output logic          o_locked,
  output logic [PW-1:0] o_int
);

  localparam logic [PW-1:0] E_MIN   = {1'b1, {(PW-1){1'b0}}};
  localparam logic [PW-1:0] E_MAX   = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] NEG_LIM = -INT_LIM;

  logic                 s1_valid, s1_gate;
  logic signed [PW-1:0] s1_e;
  logic [PW-1:0]        s1_ae;
  logic                 s2_valid;
  logic signed [PW-1:0] s2_p;
  logic signed [PW-1:0] int_q;

  logic                 gate_in;
  logic [PW-1:0]        ae_in;
  logic signed [PW-1:0] kp_term, ki_term, int_upd;
  sat_e                 sat_dir;
  logic                 det_locked;

  assign gate_in = $signed({i_mag[MW-1], i_mag}) >= $signed({1'b0, MAG_MIN});

  always_comb begin
    ae_in = i_phase;
    if (i_phase == E_MIN)
      ae_in = E_MAX;
    else if (i_phase[PW-1])
      ae_in = -i_phase;
  end

  // Shifts are taken in their own assignments so the arithmetic shift keeps signed context.
  always_comb begin
    kp_term = s1_e >>> i_kp_shift;
    ki_term = s1_e >>> i_ki_shift;
    sat_dir = sat_add({{(64-PW){int_q[PW-1]}}, int_q},
                      {{(64-PW){ki_term[PW-1]}}, ki_term},
                      {{(64-PW){1'b0}}, INT_LIM});
    case (sat_dir)
      SAT_HI:  int_upd = INT_LIM;
      SAT_LO:  int_upd = NEG_LIM;
      default: int_upd = int_q + ki_term;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_gate  <= 1'b0;
      s1_e     <= '0;
      s1_ae    <= '0;
      s2_valid <= 1'b0;
      s2_p     <= '0;
      int_q    <= '0;
      o_valid  <= 1'b0;
      o_step   <= '0;
      o_int    <= '0;
      o_locked <= 1'b0;
    end else begin
      s1_valid <= i_stb;
      if (i_stb) begin
        s1_e    <= i_phase;
        s1_gate <= gate_in;
        s1_ae   <= ae_in;
      end

      s2_valid <= s1_valid;
      if (s1_valid)
        s2_p <= s1_gate ? kp_term : '0;

      if (i_int_clr)
        int_q <= '0;
      else if (s1_valid && s1_gate)
        int_q <= int_upd;

      o_valid <= s2_valid;
      if (s2_valid) begin
        o_step   <= i_base_step + s2_p + int_q;
        o_int    <= int_q;
        o_locked <= det_locked;
      end
    end
  end

  dpll_lock_detect #(
    .PW            (PW),
    .LOCK_THRESH   (LOCK_THRESH),
    .UNLOCK_THRESH (UNLOCK_THRESH),
    .LOCK_COUNT    (LOCK_COUNT)
  ) u_lock (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (s1_valid),
    .i_gate   (s1_gate),
    .i_ae     (s1_ae),
    .o_locked (det_locked)
  );

endmodule
